// File: rtl/rv32i_encode_pkg.sv
// ----------------------------------------------------------------------------
// rv32i_encode_pkg
// Types and constants for the RV32I instruction encoder: instruction-format
// select enum, canonical NOP, the {err, instr} FIFO payload, and a helper
// that tests whether a 32-bit value is a sign-extension of its low bits.
// No ports.
// ----------------------------------------------------------------------------
package rv32i_encode_pkg;

  import rv32i_types_pkg::*;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned FMT_W   = 3;
  localparam int unsigned ENC_W   = INSTR_W + 1;

  typedef enum logic [FMT_W-1:0] {
    FMT_R       = 3'd0,
    FMT_I       = 3'd1,
    FMT_I_SHIFT = 3'd2,
    FMT_S       = 3'd3,
    FMT_SB      = 3'd4,
    FMT_U       = 3'd5,
    FMT_UJ      = 3'd6,
    FMT_RSV     = 3'd7
  } instr_fmt_t;

  // addi x0, x0, 0
  localparam logic [INSTR_W-1:0] RV32I_NOP = {25'd0, OPC_OP_IMM};

  // Payload carried through the output FIFO
  typedef struct packed {
    logic                err;
    logic [INSTR_W-1:0]  instr;
  } enc_word_t;

  // True when v[31:msb] are all copies of v[msb], i.e. v fits in a
  // (msb+1)-bit two's complement field.
  function automatic logic sext_fits(input logic [INSTR_W-1:0] v,
                                     input int unsigned         msb);
    logic fits;
    fits = 1'b1;
    for (int i = 0; i < int'(INSTR_W); i++) begin
      if ((i > int'(msb)) && (v[i] != v[msb])) begin
        fits = 1'b0;
      end
    end
    return fits;
  endfunction

endpackage : rv32i_encode_pkg

// File: rtl/rv32i_types_pkg.sv
// ----------------------------------------------------------------------------
// rv32i_types_pkg
// Shared RV32I base-ISA constants: major opcode values (instr[6:0]).
// No ports; imported by encode/decode logic and by benches.
// ----------------------------------------------------------------------------
package rv32i_types_pkg;

  localparam int unsigned OPC_W = 7;

  localparam logic [OPC_W-1:0] OPC_LOAD     = 7'h03;
  localparam logic [OPC_W-1:0] OPC_MISC_MEM = 7'h0F;
  localparam logic [OPC_W-1:0] OPC_OP_IMM   = 7'h13;
  localparam logic [OPC_W-1:0] OPC_AUIPC    = 7'h17;
  localparam logic [OPC_W-1:0] OPC_STORE    = 7'h23;
  localparam logic [OPC_W-1:0] OPC_OP       = 7'h33;
  localparam logic [OPC_W-1:0] OPC_LUI      = 7'h37;
  localparam logic [OPC_W-1:0] OPC_BRANCH   = 7'h63;
  localparam logic [OPC_W-1:0] OPC_JALR     = 7'h67;
  localparam logic [OPC_W-1:0] OPC_JAL      = 7'h6F;
  localparam logic [OPC_W-1:0] OPC_SYSTEM   = 7'h73;

endpackage : rv32i_types_pkg

// File: rtl/rv32i_instr_encoder_instr_fifo.sv
// ----------------------------------------------------------------------------
// instr_fifo
// Small synchronous FIFO with valid/ready on both sides.
//   DEPTH     : number of entries, power of two and >= 2
//   WIDTH     : payload width
// Ports:
//   CLK, RST             : clock, synchronous active-high reset
//   in_valid / in_ready  : push handshake (in_ready from registered count)
//   in_data              : payload to push
//   out_valid / out_ready: pop handshake
//   out_data             : head entry, stable while out_valid && !out_ready
// Reset clears storage so out_data reads 0 until the first push.
// ----------------------------------------------------------------------------
module instr_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 33
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             valid_q;
  logic             ready_q;
  logic             push_c;
  logic             pop_c;

  // Push is gated by the registered ready, so a full FIFO refuses a push
  // even when a pop happens in the same cycle.
  assign push_c = in_valid && ready_q;
  assign pop_c  = valid_q && out_ready;

  // Next-state pointers and occupancy; pointers wrap naturally at DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State, storage and registered handshake flags
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= (count_d != '0);
      ready_q  <= (count_d < CW'(DEPTH));
      if (push_c) begin
        mem_q[wr_ptr_q] <= in_data;
      end
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_data  = mem_q[rd_ptr_q];

endmodule : instr_fifo

// File: rtl/rv32i_instr_encoder.sv
// ----------------------------------------------------------------------------
// rv32i_instr_encoder
// Packs decoded RV32I fields back into a 32-bit instruction word for
// debug / program-buffer / self-test injection into fetch. Encoding is
// combinational; results are queued in an output FIFO of DEPTH entries.
//
// Parameters:
//   DEPTH : output FIFO entries (power of two, >= 2)
// Ports:
//   CLK, RST                   : clock, synchronous active-high reset
//   in_valid / in_ready        : field bundle handshake
//   fmt                        : instr_fmt_t format select
//   opcode, rd, rs1, rs2,
//   funct3, funct7             : raw instruction fields
//   imm                        : sign-extended immediate (decoder form)
//   out_valid / out_ready      : encoded word handshake
//   instr                      : encoded instruction
//   err                        : sideband error travelling with instr
//
// Build option:
//   IMM_RANGE_CHECK_EN : when defined, err flags immediates that do not fit
//                        their field (and the reserved format). When
//                        undefined, err is constant 0 and no check is built.
//                        The word is encoded identically in both builds.
// ----------------------------------------------------------------------------
module rv32i_instr_encoder
  import rv32i_encode_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic        err
);

  instr_fmt_t          fmt_c;
  logic [INSTR_W-1:0]  enc_instr_c;
  logic                enc_err_c;
  enc_word_t           in_word_c;
  enc_word_t           out_word_c;

  assign fmt_c = instr_fmt_t'(fmt);

  // Field packing per format; immediate bits with no slot are dropped
  always_comb begin
    enc_instr_c = RV32I_NOP;
    case (fmt_c)
      FMT_R:       enc_instr_c = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I:       enc_instr_c = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_I_SHIFT: enc_instr_c = {funct7, imm[4:0], rs1, funct3, rd, opcode};
      FMT_S:       enc_instr_c = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_SB:      enc_instr_c = {imm[12], imm[10:5], rs2, rs1, funct3,
                                  imm[4:1], imm[11], opcode};
      FMT_U:       enc_instr_c = {imm[31:12], rd, opcode};
      FMT_UJ:      enc_instr_c = {imm[20], imm[10:1], imm[11], imm[19:12],
                                  rd, opcode};
      default:     enc_instr_c = RV32I_NOP;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // Branch/jump offsets must also be even; U immediates must be 4 KiB aligned
  always_comb begin
    enc_err_c = 1'b0;
    case (fmt_c)
      FMT_I,
      FMT_S:       enc_err_c = !sext_fits(imm, 11);
      FMT_I_SHIFT: enc_err_c = (imm[31:5] != 27'd0);
      FMT_SB:      enc_err_c = !sext_fits(imm, 12) || imm[0];
      FMT_U:       enc_err_c = (imm[11:0] != 12'd0);
      FMT_UJ:      enc_err_c = !sext_fits(imm, 20) || imm[0];
      FMT_RSV:     enc_err_c = 1'b1;
      default:     enc_err_c = 1'b0;
    endcase
  end
`else
  assign enc_err_c = 1'b0;
`endif

  assign in_word_c.err   = enc_err_c;
  assign in_word_c.instr = enc_instr_c;

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENC_W)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_word_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_word_c)
  );

  assign instr = out_word_c.instr;
  assign err   = out_word_c.err;

endmodule : rv32i_instr_encoder

// File: tb/tb_rv32i_instr_encoder.sv
// ----------------------------------------------------------------------------
// tb_rv32i_instr_encoder
// Table of field bundles with hand-encoded expected words; expected
// {err, instr} pushed to a scoreboard queue on acceptance and compared
// when the DUT pops. Hand sequences cover reset state, first-word latency,
// backpressure with DEPTH=2 and a mid-stream reset flush.
// ----------------------------------------------------------------------------
module tb_rv32i_instr_encoder;

  import rv32i_types_pkg::*;
  import rv32i_encode_pkg::*;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp_instr;
    logic        chk_err;
  } vec_t;

  logic        CLK;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        err;

  int          total;
  int          bad;
  logic        rnd_en;
  logic [32:0] sb_q [$];
  vec_t        tbl [16];

  rv32i_instr_encoder #(.DEPTH(2)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fmt       (fmt),
    .opcode    (opcode),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7    (funct7),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr     (instr),
    .err       (err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  function automatic vec_t mk(input logic [2:0] f, input logic [6:0] op,
                              input logic [4:0] rd_, input logic [4:0] rs1_,
                              input logic [4:0] rs2_, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] im,
                              input logic [31:0] ex, input logic ce);
    vec_t v;
    v.fmt = f; v.op = op; v.rd = rd_; v.rs1 = rs1_; v.rs2 = rs2_;
    v.f3 = f3; v.f7 = f7; v.imm = im; v.exp_instr = ex; v.chk_err = ce;
    return v;
  endfunction

  function automatic logic exp_err(input vec_t v);
`ifdef IMM_RANGE_CHECK_EN
    return v.chk_err;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [32:0] exp_word(input vec_t v);
    return {exp_err(v), v.exp_instr};
  endfunction

  task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    fmt    = v.fmt;
    opcode = v.op;
    rd     = v.rd;
    rs1    = v.rs1;
    rs2    = v.rs2;
    funct3 = v.f3;
    funct7 = v.f7;
    imm    = v.imm;
  endtask

  // Present a bundle from a negedge; it is accepted at the first posedge
  // that follows a sample of in_ready=1.
  task automatic send(input vec_t v);
    int n;
    n = 0;
    @(negedge CLK);
    drive(v);
    in_valid = 1'b1;
    #4;
    while (!in_ready && n < 200) begin
      @(negedge CLK);
      #4;
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout got=in_ready_low want=accept");
    end else begin
      sb_q.push_back(exp_word(v));
    end
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge CLK);
    out_ready = 1'b1;
    while (sb_q.size() != 0 && n < 1000) begin
      @(negedge CLK);
      n++;
    end
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout got=%0d want=0", sb_q.size());
    end
    #4;
    chk("drain_idle", 33'(out_valid), 33'd0);
  endtask

  // Scoreboard monitor: sample just before each rising edge
  initial begin
    forever begin
      @(negedge CLK);
      #4;
      if (!RST && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_empty got=%h want=none", {err, instr});
        end else begin
          chk("sb_word", {err, instr}, sb_q.pop_front());
        end
      end
    end
  end

  // Random consumer backpressure
  initial begin
    forever begin
      @(negedge CLK);
      if (rnd_en) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    tbl[0]  = mk(FMT_I,       OPC_OP_IMM, 5'd1,  5'd0, 5'd31, 3'd0, 7'h7f, 32'd5,        32'h00500093, 1'b0);
    tbl[1]  = mk(FMT_S,       OPC_STORE,  5'd17, 5'd3, 5'd2,  3'd2, 7'h00, 32'hFFFFFFFC, 32'hFE21AE23, 1'b0);
    tbl[2]  = mk(FMT_UJ,      OPC_JAL,    5'd1,  5'd0, 5'd0,  3'd0, 7'h00, 32'd8,        32'h008000EF, 1'b0);
    tbl[3]  = mk(FMT_R,       OPC_OP,     5'd3,  5'd1, 5'd2,  3'd0, 7'h20, 32'hFFFFFFFF, 32'h402081B3, 1'b0);
    tbl[4]  = mk(FMT_I_SHIFT, OPC_OP_IMM, 5'd5,  5'd6, 5'd0,  3'd5, 7'h20, 32'd3,        32'h40335293, 1'b0);
    tbl[5]  = mk(FMT_SB,      OPC_BRANCH, 5'd0,  5'd1, 5'd2,  3'd0, 7'h00, 32'hFFFFFFF8, 32'hFE208CE3, 1'b0);
    tbl[6]  = mk(FMT_U,       OPC_LUI,    5'd5,  5'd9, 5'd9,  3'd7, 7'h00, 32'h12345000, 32'h123452B7, 1'b0);
    tbl[7]  = mk(FMT_RSV,     OPC_OP,     5'd3,  5'd1, 5'd2,  3'd0, 7'h00, 32'd5,        32'h00000013, 1'b1);
    tbl[8]  = mk(FMT_SB,      OPC_BRANCH, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00, 32'd3,        32'h00000163, 1'b1);
    tbl[9]  = mk(FMT_I,       OPC_OP_IMM, 5'd1,  5'd0, 5'd0,  3'd0, 7'h00, 32'd2048,     32'h80000093, 1'b1);
    tbl[10] = mk(FMT_I_SHIFT, OPC_OP_IMM, 5'd1,  5'd1, 5'd0,  3'd1, 7'h00, 32'd32,       32'h00009093, 1'b1);
    tbl[11] = mk(FMT_UJ,      OPC_JAL,    5'd0,  5'd0, 5'd0,  3'd0, 7'h00, 32'h00100000, 32'h8000006F, 1'b1);
    tbl[12] = mk(FMT_U,       OPC_LUI,    5'd1,  5'd0, 5'd0,  3'd0, 7'h00, 32'h00001001, 32'h000010B7, 1'b1);
    tbl[13] = mk(FMT_S,       OPC_STORE,  5'd0,  5'd0, 5'd0,  3'd2, 7'h00, 32'hFFFFF800, 32'h80002023, 1'b0);
    tbl[14] = mk(FMT_SB,      OPC_BRANCH, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00, 32'h00000FFE, 32'h7E000FE3, 1'b0);
    tbl[15] = mk(FMT_UJ,      OPC_JAL,    5'd0,  5'd0, 5'd0,  3'd0, 7'h00, 32'hFFF00000, 32'h8000006F, 1'b0);

    rnd_en    = 1'b0;
    RST       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive(tbl[0]);
    repeat (3) @(posedge CLK);

    // Reset state
    @(negedge CLK);
    #4;
    chk("rst_out_valid", 33'(out_valid), 33'd0);
    chk("rst_in_ready",  33'(in_ready),  33'd1);
    chk("rst_instr",     33'(instr),     33'd0);
    chk("rst_err",       33'(err),       33'd0);
    @(negedge CLK);
    RST       = 1'b0;
    out_ready = 1'b1;

    // First word appears right after its accepting edge
    send(tbl[0]);
    #3;
    chk("lat_valid", 33'(out_valid), 33'd1);
    chk("lat_instr", 33'(instr),     33'h00500093);

    // Table sweep under random backpressure
    rnd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(tbl[i]);
    end
    rnd_en = 1'b0;
    drain();

    // Backpressure: two accepted, third held until a slot frees
    @(negedge CLK);
    out_ready = 1'b0;
    send(tbl[3]);
    send(tbl[4]);
    @(negedge CLK);
    drive(tbl[6]);
    in_valid = 1'b1;
    #4;
    chk("bp_full",       33'(in_ready),  33'd0);
    chk("bp_valid",      33'(out_valid), 33'd1);
    chk("bp_head",       {err, instr},   exp_word(tbl[3]));
    @(negedge CLK);
    #4;
    chk("bp_still_full", 33'(in_ready),  33'd0);
    chk("bp_hold",       {err, instr},   exp_word(tbl[3]));
    @(negedge CLK);
    out_ready = 1'b1;
    #4;
    chk("bp_no_comb",    33'(in_ready),  33'd0);
    @(negedge CLK);
    #4;
    chk("bp_reopen",     33'(in_ready),  33'd1);
    if (in_ready) sb_q.push_back(exp_word(tbl[6]));
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    drain();

    // Mid-stream reset flushes queued words and the in-flight bundle
    @(negedge CLK);
    out_ready = 1'b0;
    send(tbl[1]);
    send(tbl[2]);
    @(negedge CLK);
    RST = 1'b1;
    drive(tbl[5]);
    in_valid = 1'b1;
    sb_q.delete();
    @(negedge CLK);
    RST      = 1'b0;
    in_valid = 1'b0;
    #4;
    chk("rf_out_valid", 33'(out_valid), 33'd0);
    chk("rf_in_ready",  33'(in_ready),  33'd1);
    chk("rf_instr",     33'(instr),     33'd0);
    chk("rf_err",       33'(err),       33'd0);
    @(negedge CLK);
    out_ready = 1'b1;
    send(tbl[13]);
    #3;
    chk("rf_first", {err, instr}, exp_word(tbl[13]));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rv32i_instr_encoder
